// File: rtl/alu_defs_pkg.sv
// Shared ALU definitions: FSM encoding, nibble width and ALU op codes for the
// multi-cycle arithmetic path.
package alu_defs;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    ALU_ADD  = 2'd0,
    ALU_ADDU = 2'd1,
    ALU_SUB  = 2'd2,
    ALU_SUBU = 2'd3
  } alu_op_t;

  // Drives the adder's sub input from the decoded ALU op.
  function automatic logic alu_op_is_sub(alu_op_t op);
    return (op == ALU_SUB) || (op == ALU_SUBU);
  endfunction

endpackage

// File: rtl/four_bit_cla_adder.sv
// 4-bit carry-lookahead adder; all carries derived in parallel from g/p terms.
module four_bit_cla_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] r,
  output logic       cout
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
    r    = p ^ c[3:0];
    cout = c[4];
  end

endmodule

// File: rtl/serial_cla_adder_ctrl.sv
// Multi-cycle add/subtract: one 4-bit CLA reused across all nibbles, LSB first,
// with the carry registered between cycles.
module serial_cla_adder_ctrl
  import alu_defs::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero
);

  localparam int unsigned NUM_NIB = WIDTH / NIBBLE_W;
  localparam int unsigned CNT_W   = (NUM_NIB > 1) ? $clog2(NUM_NIB) : 1;
  localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(NUM_NIB - 1);

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, res_q, res_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              cy_q, cy_d;
  logic              a_msb_q, a_msb_d, b_msb_q, b_msb_d;
  logic              carry_q, carry_d, ovf_q, ovf_d, zero_q, zero_d;

  logic [NIBBLE_W-1:0] sum_nib;
  logic                nib_cout;
  logic [WIDTH-1:0]    res_shift;

  four_bit_cla_adder u_cla (
    .a    (a_q[NIBBLE_W-1:0]),
    .b    (b_q[NIBBLE_W-1:0]),
    .cin  (cy_q),
    .r    (sum_nib),
    .cout (nib_cout)
  );

  assign res_shift = {sum_nib, res_q[WIDTH-1:NIBBLE_W]};

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    cy_d    = cy_q;
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          // Subtraction is A + ~B + 1: invert B here, the +1 enters as initial carry.
          a_d     = op_a;
          b_d     = op_b ^ {WIDTH{sub}};
          cy_d    = sub;
          cnt_d   = '0;
          res_d   = '0;
          carry_d = 1'b0;
          ovf_d   = 1'b0;
          zero_d  = 1'b0;
          a_msb_d = op_a[WIDTH-1];
          b_msb_d = op_b[WIDTH-1] ^ sub;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        res_d = res_shift;
        a_d   = a_q >> NIBBLE_W;
        b_d   = b_q >> NIBBLE_W;
        cy_d  = nib_cout;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_NIB) begin
          // Flags registered on the last nibble so they are valid with done.
          carry_d = nib_cout;
          ovf_d   = (a_msb_q == b_msb_q) && (res_shift[WIDTH-1] != a_msb_q);
          zero_d  = (res_shift == '0);
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      cy_q    <= 1'b0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      cy_q    <= cy_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign result   = res_q;
  assign carry    = carry_q;
  assign overflow = ovf_q;
  assign zero     = zero_q;

endmodule

// File: tb/tb_serial_cla_adder_ctrl.sv
// Bench for serial_cla_adder_ctrl: vector table plus scoreboard, with handshake
// and mid-operation reset sequences.
module tb_serial_cla_adder_ctrl;

  logic        clk, rst, start, sub;
  logic [31:0] op_a, op_b, result;
  logic        busy, done, carry, overflow, zero;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] res;
    logic        c, v, z;
  } exp_t;

  typedef struct {
    logic [31:0] a, b;
    logic        sub;
    exp_t        e;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[10];

  serial_cla_adder_ctrl #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .sub      (sub),
    .op_a     (op_a),
    .op_b     (op_b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .carry    (carry),
    .overflow (overflow),
    .zero     (zero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
    exp_t e;
    logic [32:0] w;
    if (!s) begin
      w     = {1'b0, a} + {1'b0, b};
      e.res = w[31:0];
      e.c   = w[32];
      e.v   = (a[31] == b[31]) && (e.res[31] != a[31]);
    end else begin
      e.res = a - b;
      e.c   = (a >= b);
      e.v   = (a[31] != b[31]) && (e.res[31] != a[31]);
    end
    e.z = (e.res == 32'h0);
    return e;
  endfunction

  // Scoreboard: compare every done pulse against the oldest expected result.
  always @(negedge clk) begin
    if (done) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending op at %0t", $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", result, e.res);
        chk("carry", {31'b0, carry}, {31'b0, e.c});
        chk("overflow", {31'b0, overflow}, {31'b0, e.v});
        chk("zero", {31'b0, zero}, {31'b0, e.z});
      end
    end
  end

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input exp_t e);
    int got;
    @(negedge clk);
    start = 1'b1; op_a = a; op_b = b; sub = s;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0; op_a = $urandom; op_b = $urandom; sub = 1'b0;
    got = 0;
    for (int i = 1; i <= 20; i++) begin
      if (i > 1) @(negedge clk);
      if (done) begin
        got = i;
        break;
      end
    end
    chk("latency", got, 32'd9);
    @(negedge clk);
    chk("busy_after", {31'b0, busy}, 32'd0);
    chk("result_hold", result, e.res);
  endtask

  initial begin
    vecs[0] = '{32'h0000000F, 32'h00000001, 1'b0, '{32'h00000010, 1'b0, 1'b0, 1'b0}};
    vecs[1] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, '{32'h80000000, 1'b0, 1'b1, 1'b0}};
    vecs[2] = '{32'h80000000, 32'h00000001, 1'b1, '{32'h7FFFFFFF, 1'b1, 1'b1, 1'b0}};
    vecs[3] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, '{32'h00000000, 1'b1, 1'b0, 1'b1}};
    vecs[4] = '{32'h00000005, 32'h00000005, 1'b1, '{32'h00000000, 1'b1, 1'b0, 1'b1}};
    vecs[5] = '{32'h00000003, 32'h00000005, 1'b1, '{32'hFFFFFFFE, 1'b0, 1'b0, 1'b0}};
    vecs[6] = '{32'h12345678, 32'h9ABCDEF0, 1'b0, '{32'hACF13568, 1'b0, 1'b0, 1'b0}};
    vecs[7] = '{32'h80000000, 32'h80000000, 1'b0, '{32'h00000000, 1'b1, 1'b1, 1'b1}};
    vecs[8] = '{32'h00000000, 32'h00000000, 1'b1, '{32'h00000000, 1'b1, 1'b0, 1'b1}};
    vecs[9] = '{32'hFFFFFFFF, 32'h00000001, 1'b1, '{32'hFFFFFFFE, 1'b1, 1'b0, 1'b0}};

    rst = 1'b0; start = 1'b0; sub = 1'b0; op_a = '0; op_b = '0;
    #1 rst = 1'b1;
    #2;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_flags", {29'b0, carry, overflow, zero}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) run_op(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].e);

    for (int i = 0; i < 6; i++) begin
      logic [31:0] a, b;
      logic s;
      a = $urandom; b = $urandom; s = 1'($urandom_range(0, 1));
      run_op(a, b, s, model(a, b, s));
    end

    // Start held high through the whole operation: only cycle 0 and cycle 10 accept.
    @(negedge clk);
    start = 1'b1; op_a = 32'd1; op_b = 32'd2; sub = 1'b0;
    sb.push_back(model(32'd1, 32'd2, 1'b0));
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      chk("hs_busy", {31'b0, busy}, 32'd1);
      chk("hs_done", {31'b0, done}, {31'b0, (i == 9)});
      op_a = 32'(i * 100); op_b = 32'(i * 7); sub = 1'(i);
    end
    @(negedge clk);
    chk("hs_idle_busy", {31'b0, busy}, 32'd0);
    op_a = 32'd10; op_b = 32'd20; sub = 1'b0;
    sb.push_back(model(32'd10, 32'd20, 1'b0));
    @(negedge clk);
    start = 1'b0;
    chk("hs2_busy", {31'b0, busy}, 32'd1);
    for (int i = 12; i <= 21; i++) begin
      @(negedge clk);
      chk("hs2_done", {31'b0, done}, {31'b0, (i == 19)});
      chk("hs2_busy", {31'b0, busy}, {31'b0, (i <= 19)});
    end

    // Asynchronous reset in cycle 4 of an operation; no done may follow.
    @(negedge clk);
    start = 1'b1; op_a = 32'h11111111; op_b = 32'h22222222; sub = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_busy", {31'b0, busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", {31'b0, busy}, 32'd0);
    chk("arst_done", {31'b0, done}, 32'd0);
    chk("arst_result", result, 32'd0);
    chk("arst_flags", {29'b0, carry, overflow, zero}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("post_rst_done", {31'b0, done}, 32'd0);
    end
    run_op(32'd2, 32'd3, 1'b0, '{32'd5, 1'b0, 1'b0, 1'b0});

    repeat (2) @(negedge clk);
    chk("sb_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
